// File: rtl/mysystem_debounce_pkg.sv
// ---------------------------------------------------------------------------
// mysystem_debounce_pkg
//
// Shared definitions for the push-button debouncer:
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles needed to accept a new key level
//                             (10 ms at 50 MHz)
//   KEY_IDLE                : level of a released (active-low) key
//   cnt_width()             : width of the per-channel stability counter
// ---------------------------------------------------------------------------
package mysystem_debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Keys are active-low; an idle/released key reads as 1.
  localparam logic KEY_IDLE = 1'b1;

  // The counter only has to reach cycles-1, so $clog2(cycles) bits suffice.
  // Clamp to one bit so tiny thresholds still yield a legal vector.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : mysystem_debounce_pkg

// File: rtl/mysystem_debounce_channel.sv
// ---------------------------------------------------------------------------
// mysystem_debounce_channel
//
// One key channel: two-flop synchroniser, stability counter and registered
// press/release strobes.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   key_raw      in   asynchronous raw key, active-low
//   key_clean    out  debounced level, active-low, registered
//   key_press    out  one-cycle strobe when key_clean goes 1->0
//   key_release  out  one-cycle strobe when key_clean goes 0->1
// ---------------------------------------------------------------------------
module mysystem_debounce_channel
  import mysystem_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT  // must be >= 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean,
  output logic key_press,
  output logic key_release
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] cnt_nxt;
  logic             clean_nxt;
  logic             press_nxt;
  logic             release_nxt;

  // Any sample equal to the accepted level clears the count, so a bounce
  // back before qualification discards all accumulated credit. The count
  // stops at CNT_LAST and is cleared on acceptance, so it never wraps.
  always_comb begin
    cnt_nxt     = '0;
    clean_nxt   = key_clean;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (sync != key_clean) begin
      if (cnt == CNT_LAST) begin
        clean_nxt   = sync;
        press_nxt   = ~sync;
        release_nxt = sync;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Reset forces every flop to the released state, so a key held through
  // reset must re-qualify from scratch and no strobe is emitted by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1     <= KEY_IDLE;
      sync        <= KEY_IDLE;
      key_clean   <= KEY_IDLE;
      cnt         <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_q1     <= key_raw;
      sync        <= sync_q1;
      key_clean   <= clean_nxt;
      cnt         <= cnt_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

endmodule : mysystem_debounce_channel

// File: rtl/mysystem_button_debounce.sv
// ---------------------------------------------------------------------------
// mysystem_button_debounce
//
// Per-channel push-button debouncer feeding the pushbutton PIO in_port.
// Each channel is an independent mysystem_debounce_channel instance.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   key_raw      in   [WIDTH] asynchronous raw keys, active-low
//   key_clean    out  [WIDTH] debounced keys, active-low, registered
//   key_press    out  [WIDTH] one-cycle strobe per channel on 1->0
//   key_release  out  [WIDTH] one-cycle strobe per channel on 0->1
// ---------------------------------------------------------------------------
module mysystem_button_debounce
  import mysystem_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_clean,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_ch
    mysystem_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw[i]),
      .key_clean  (key_clean[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule : mysystem_button_debounce

// File: tb/tb_mysystem_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_mysystem_button_debounce
//
// Directed bench for the debouncer with DEBOUNCE_CYCLES = 8, WIDTH = 4.
// A new raw level sampled on edge 1 reaches key_clean on edge 10, with the
// strobe visible in the same cycle.
// ---------------------------------------------------------------------------
module tb_mysystem_button_debounce;

  localparam int W  = 4;
  localparam int DC = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] key_raw;
  logic [W-1:0] key_clean;
  logic [W-1:0] key_press;
  logic [W-1:0] key_release;

  mysystem_button_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .key_clean  (key_clean),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] press;
    logic [W-1:0] rel;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic void add(input int n, input logic rst, input logic [W-1:0] raw,
                              input logic [W-1:0] clean, input logic [W-1:0] press,
                              input logic [W-1:0] rel);
    vec_t v;
    v.rst   = rst;
    v.raw   = raw;
    v.clean = clean;
    v.press = press;
    v.rel   = rel;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  function automatic void check(input string name, input logic [W-1:0] got,
                                input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endfunction

  function automatic void check_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    reset   = 1'b1;
    key_raw = '1;

    // Reset with all keys held down, then qualify all four after release.
    add(3, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    add(9, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Release all four.
    add(9, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
    add(1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    // Clean press on channel 0.
    add(9, 1'b0, 4'b1110, 4'b1111, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b1110, 4'b1110, 4'b0001, 4'b0000);
    add(2, 1'b0, 4'b1110, 4'b1110, 4'b0000, 4'b0000);
    // Channel 1: low 7, high 1 (rejected just short of qualifying), low again.
    add(7, 1'b0, 4'b1100, 4'b1110, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b1110, 4'b1110, 4'b0000, 4'b0000);
    add(9, 1'b0, 4'b1100, 4'b1110, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b1100, 4'b1100, 4'b0010, 4'b0000);
    add(1, 1'b0, 4'b1100, 4'b1100, 4'b0000, 4'b0000);
    // Channel 2: 5-cycle glitch, fully rejected.
    add(5, 1'b0, 4'b1000, 4'b1100, 4'b0000, 4'b0000);
    add(12, 1'b0, 4'b1100, 4'b1100, 4'b0000, 4'b0000);
    // Release channel 0.
    add(9, 1'b0, 4'b1101, 4'b1100, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b1101, 4'b1101, 4'b0000, 4'b0001);
    add(1, 1'b0, 4'b1101, 4'b1101, 4'b0000, 4'b0000);
    // Press channels 0 and 3 together, then release them together.
    add(9, 1'b0, 4'b0100, 4'b1101, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b0100, 4'b0100, 4'b1001, 4'b0000);
    add(1, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    add(9, 1'b0, 4'b1101, 4'b0100, 4'b0000, 4'b0000);
    add(1, 1'b0, 4'b1101, 4'b1101, 4'b0000, 4'b1001);
    add(1, 1'b0, 4'b1101, 4'b1101, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      key_raw = vecs[i].raw;
      tick();
      check($sformatf("vec%0d clean", i),   key_clean,   vecs[i].clean);
      check($sformatf("vec%0d press", i),   key_press,   vecs[i].press);
      check($sformatf("vec%0d release", i), key_release, vecs[i].rel);
    end

    // Reset mid-count: channel 0 starts qualifying; after 7 edges its count is 5.
    key_raw = 4'b1100;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("midcnt%0d clean", i), key_clean, 4'b1101);
      check($sformatf("midcnt%0d press", i), key_press, 4'b0000);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("midrst%0d clean", i),   key_clean,   4'b1111);
      check($sformatf("midrst%0d press", i),   key_press,   4'b0000);
      check($sformatf("midrst%0d release", i), key_release, 4'b0000);
    end
    reset = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (key_press == 4'b0000) begin
        check($sformatf("requal%0d clean", n), key_clean, 4'b1111);
      end
    end while (key_press == 4'b0000 && n < 20);
    check_int("requal edges", n, DC + 2);
    check("requal press", key_press, 4'b0011);
    check("requal clean", key_clean, 4'b1100);
    tick();
    check("requal press end", key_press, 4'b0000);
    check("requal clean hold", key_clean, 4'b1100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mysystem_button_debounce
